csr_file: RTL
=============

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have ports: clk in 1, system clock; resetn in 1, reset; reset is synchronous, active-low, and sampled on the rising edge of clk.
REQ-002 SHALL have read port: csr_re in 1; csr_rd_num in 14; csr_rd_value out 32, combinational.
REQ-003 SHALL have write port: csr_we in 1; csr_wr_num in 14; csr_wr_mask in 32; csr_wr_value in 32.
REQ-004 SHALL have exception inputs: wb_exc in 6, one-hot {ADEF,ALE,BRK,INE,SYS,INT} (bit5..bit0); ertn_flush in 1; wb_pc in 32; wb_fault_vaddr in 32.
REQ-005 SHALL have interrupt inputs: hw_int_in in 8; ipi_int_in in 1.
REQ-006 SHALL have outputs: ex_entry out 32 (EENTRY); ertn_entry out 32 (ERA); has_int out 1.

Function
REQ-007 SHALL implement the following CSRs: CRMD 0x0 {DA[3],IE[2],PLV[1:0]}; PRMD 0x1 {PIE[2],PPLV[1:0]}; ECFG 0x4 LIE[12:0], writable mask 0x1BFF; ESTAT 0x5 {EsubCode[30:22],Ecode[21:16],IS[12:0]}; ERA 0x6; BADV 0x7; EENTRY 0xC, bits [31:6] writable; SAVE0-3 0x30-0x33; TID 0x40; TCFG 0x41 {InitVal[31:2],Periodic[1],En[0]}; TVAL 0x42, read-only; TICLR 0x44.
REQ-008 On a write, each writable field SHALL update as new = (old & ~mask) | (value & mask); unimplemented bits SHALL read 0.
REQ-009 csr_rd_value SHALL return the register's pre-edge contents; a write in cycle N SHALL be visible in cycle N+1; an unmapped number or csr_re=0 SHALL read 0.
REQ-010 ESTAT.IS[1:0] SHALL be software-writable; IS[9:2] SHALL be loaded from hw_int_in every cycle; IS[12] SHALL be loaded from ipi_int_in every cycle; IS[10] SHALL be 0.
REQ-011 Timer: a TCFG write SHALL load TVAL <= {new InitVal,2'b00}.
REQ-012 Timer: otherwise, when En=1 and TVAL!=0xFFFFFFFF, TVAL SHALL decrement by 1 per cycle.
REQ-013 Timer: when TVAL==0 with Periodic=1, TVAL SHALL reload {InitVal,2'b00} instead of decrementing.
REQ-014 Timer: in one-shot mode, TVAL SHALL wrap from 0 to 0xFFFFFFFF and hold there.
REQ-015 Timer: TVAL==0 with En=1 SHALL set IS[11].
REQ-016 A TICLR write with mask[0]&value[0] SHALL clear IS[11]; a simultaneous timer set SHALL win; TICLR SHALL read 0.
REQ-017 has_int SHALL equal CRMD.IE & |(IS[12:0] & LIE[12:0]).
REQ-018 On any wb_exc bit, in one cycle: PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE; CRMD.PLV<=0; CRMD.IE<=0; ERA<=wb_pc; EsubCode<=0.
REQ-019 On an exception, Ecode SHALL be loaded as: INT 0x0, ADEF 0x8, ALE 0x9, SYS 0xB, BRK 0xC, INE 0xD.
REQ-020 If more than one wb_exc bit is set, the priority order SHALL be INT > ADEF > INE > BRK > SYS > ALE.
REQ-021 On an exception, BADV SHALL be set to wb_pc for ADEF and to wb_fault_vaddr for ALE; BADV SHALL be unchanged otherwise.
REQ-022 ertn_flush SHALL restore CRMD.PLV<=PRMD.PPLV and CRMD.IE<=PRMD.PIE.
REQ-023 An exception SHALL take priority over a simultaneous ertn_flush.
REQ-024 An exception SHALL take priority over a simultaneous csr_we to CRMD, PRMD, ERA, ESTAT, or BADV.
REQ-025 ex_entry SHALL equal {EENTRY[31:6],6'b0}; ertn_entry SHALL equal ERA.

Reset
REQ-026 While resetn=0: CRMD=0x00000008 (DA=1, PLV0, IE0); TCFG.En=0; TVAL=0xFFFFFFFF; all other CSRs 0; has_int=0.
REQ-027 Reset SHALL override any in-flight timer count, exception, or write in the same cycle.

Verification
REQ-028 Reset released -> reads CRMD=0x8, TVAL=0xFFFFFFFF, ESTAT=0, has_int=0.
REQ-029 Write TCFG=0x0000000B (InitVal=2, periodic, En) -> TVAL reads 8,7,...,0; IS[11] set; next cycle TVAL=8; TICLR value=1 then clears IS[11].
REQ-030 Set CRMD.PLV=3, IE=1; assert wb_exc=6'b100000 with wb_pc=0x1C000100 -> CRMD PLV0/IE0; PRMD=0x7; ERA=0x1C000100; Ecode=0x8; BADV=0x1C000100.
REQ-031 Next, assert ertn_flush -> CRMD.PLV=3, IE=1; ertn_entry=0x1C000100.
REQ-032 ECFG=0x800, CRMD.IE=1, one-shot InitVal=1 -> has_int=1 when TVAL reaches 0; TVAL then holds at 0xFFFFFFFF.
REQ-033 Same cycle: csr_we to ERA with 0x1234 and wb_exc=6'b000010 (SYS) -> ERA=wb_pc; Ecode=0xB.

Source files
------------

// File: rtl/csr_file.sv
// Control/status register file: privilege state, exception capture and return,
// interrupt status/enable, and a down-counting timer with one-shot or periodic reload.
module csr_file (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_rd_num,
    output logic [31:0] csr_rd_value,
    input  logic        csr_we,
    input  logic [13:0] csr_wr_num,
    input  logic [31:0] csr_wr_mask,
    input  logic [31:0] csr_wr_value,
    input  logic [5:0]  wb_exc,
    input  logic        ertn_flush,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_fault_vaddr,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    // wb_exc bit positions
    localparam int EXC_INT  = 0;
    localparam int EXC_SYS  = 1;
    localparam int EXC_INE  = 2;
    localparam int EXC_BRK  = 3;
    localparam int EXC_ALE  = 4;
    localparam int EXC_ADEF = 5;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [12:0] LIE_WMASK = 13'h1BFF;

    logic [3:0]  crmd_q, crmd_d;
    logic [2:0]  prmd_q, prmd_d;
    logic [12:0] lie_q, lie_d;
    logic [12:0] is_q, is_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esubcode_q, esubcode_d;
    logic [31:0] era_q, era_d;
    logic [31:0] badv_q, badv_d;
    logic [25:0] eentry_q, eentry_d;
    logic [31:0] save_q [4];
    logic [31:0] save_d [4];
    logic [31:0] tid_q, tid_d;
    logic [31:0] tcfg_q, tcfg_d;
    logic [31:0] tval_q, tval_d;

    logic        exc;
    logic [31:0] wval;
    logic        wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv;
    logic        wr_eentry, wr_tid, wr_tcfg, wr_ticlr;
    logic [3:0]  save_we;
    logic        timer_fire;
    logic        ticlr_hit;
    logic [5:0]  exc_code;
    logic        badv_from_pc;
    logic        badv_from_vaddr;

    assign exc  = |wb_exc;
    assign wval = csr_wr_value & csr_wr_mask;

    // Architectural state touched by an exception ignores a same-cycle software write.
    assign wr_crmd   = csr_we && (csr_wr_num == CSR_CRMD)  && !exc;
    assign wr_prmd   = csr_we && (csr_wr_num == CSR_PRMD)  && !exc;
    assign wr_estat  = csr_we && (csr_wr_num == CSR_ESTAT) && !exc;
    assign wr_era    = csr_we && (csr_wr_num == CSR_ERA)   && !exc;
    assign wr_badv   = csr_we && (csr_wr_num == CSR_BADV)  && !exc;
    assign wr_ecfg   = csr_we && (csr_wr_num == CSR_ECFG);
    assign wr_eentry = csr_we && (csr_wr_num == CSR_EENTRY);
    assign wr_tid    = csr_we && (csr_wr_num == CSR_TID);
    assign wr_tcfg   = csr_we && (csr_wr_num == CSR_TCFG);
    assign wr_ticlr  = csr_we && (csr_wr_num == CSR_TICLR);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_save_we
            assign save_we[gi] = csr_we && (csr_wr_num == CSR_SAVE0 + 14'(gi));
        end
    endgenerate

    assign timer_fire = tcfg_q[0] && (tval_q == 32'h0);
    assign ticlr_hit  = wr_ticlr && csr_wr_mask[0] && csr_wr_value[0];

    // Exception cause priority: INT > ADEF > INE > BRK > SYS > ALE.
    always_comb begin
        exc_code        = ECODE_ALE;
        badv_from_pc    = 1'b0;
        badv_from_vaddr = 1'b0;
        if (wb_exc[EXC_INT]) begin
            exc_code = ECODE_INT;
        end else if (wb_exc[EXC_ADEF]) begin
            exc_code     = ECODE_ADEF;
            badv_from_pc = 1'b1;
        end else if (wb_exc[EXC_INE]) begin
            exc_code = ECODE_INE;
        end else if (wb_exc[EXC_BRK]) begin
            exc_code = ECODE_BRK;
        end else if (wb_exc[EXC_SYS]) begin
            exc_code = ECODE_SYS;
        end else if (wb_exc[EXC_ALE]) begin
            exc_code        = ECODE_ALE;
            badv_from_vaddr = 1'b1;
        end
    end

    always_comb begin
        crmd_d     = crmd_q;
        prmd_d     = prmd_q;
        lie_d      = lie_q;
        is_d       = is_q;
        ecode_d    = ecode_q;
        esubcode_d = esubcode_q;
        era_d      = era_q;
        badv_d     = badv_q;
        eentry_d   = eentry_q;
        save_d     = save_q;
        tid_d      = tid_q;
        tcfg_d     = tcfg_q;
        tval_d     = tval_q;

        if (wr_crmd)   crmd_d   = (crmd_q & ~csr_wr_mask[3:0]) | wval[3:0];
        if (wr_prmd)   prmd_d   = (prmd_q & ~csr_wr_mask[2:0]) | wval[2:0];
        if (wr_ecfg)   lie_d    = (lie_q & ~(csr_wr_mask[12:0] & LIE_WMASK)) | (wval[12:0] & LIE_WMASK);
        if (wr_era)    era_d    = (era_q & ~csr_wr_mask) | wval;
        if (wr_badv)   badv_d   = (badv_q & ~csr_wr_mask) | wval;
        if (wr_eentry) eentry_d = (eentry_q & ~csr_wr_mask[31:6]) | wval[31:6];
        if (wr_tid)    tid_d    = (tid_q & ~csr_wr_mask) | wval;
        if (wr_tcfg)   tcfg_d   = (tcfg_q & ~csr_wr_mask) | wval;
        for (int i = 0; i < 4; i++) begin
            if (save_we[i]) save_d[i] = (save_q[i] & ~csr_wr_mask) | wval;
        end

        if (wr_estat) is_d[1:0] = (is_q[1:0] & ~csr_wr_mask[1:0]) | wval[1:0];
        is_d[9:2] = hw_int_in;
        is_d[10]  = 1'b0;
        is_d[11]  = timer_fire | (is_q[11] & ~ticlr_hit);
        is_d[12]  = ipi_int_in;

        if (exc) begin
            prmd_d     = crmd_q[2:0];
            crmd_d     = {crmd_q[3], 3'b000};
            era_d      = wb_pc;
            ecode_d    = exc_code;
            esubcode_d = 9'h0;
            if (badv_from_pc)    badv_d = wb_pc;
            if (badv_from_vaddr) badv_d = wb_fault_vaddr;
        end else if (ertn_flush) begin
            // PIE/PPLV sit in the same bit positions as IE/PLV.
            crmd_d[2:0] = prmd_q;
        end

        if (wr_tcfg) begin
            tval_d = {tcfg_d[31:2], 2'b00};
        end else if (tcfg_q[0] && (tval_q != 32'hFFFF_FFFF)) begin
            if ((tval_q == 32'h0) && tcfg_q[1]) tval_d = {tcfg_q[31:2], 2'b00};
            else                                 tval_d = tval_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            crmd_q     <= 4'h8;
            prmd_q     <= '0;
            lie_q      <= '0;
            is_q       <= '0;
            ecode_q    <= '0;
            esubcode_q <= '0;
            era_q      <= '0;
            badv_q     <= '0;
            eentry_q   <= '0;
            tid_q      <= '0;
            tcfg_q     <= '0;
            tval_q     <= 32'hFFFF_FFFF;
            for (int i = 0; i < 4; i++) save_q[i] <= '0;
        end else begin
            crmd_q     <= crmd_d;
            prmd_q     <= prmd_d;
            lie_q      <= lie_d;
            is_q       <= is_d;
            ecode_q    <= ecode_d;
            esubcode_q <= esubcode_d;
            era_q      <= era_d;
            badv_q     <= badv_d;
            eentry_q   <= eentry_d;
            tid_q      <= tid_d;
            tcfg_q     <= tcfg_d;
            tval_q     <= tval_d;
            for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
        end
    end

    always_comb begin
        csr_rd_value = '0;
        if (csr_re) begin
            case (csr_rd_num)
                CSR_CRMD:   csr_rd_value = {28'h0, crmd_q};
                CSR_PRMD:   csr_rd_value = {29'h0, prmd_q};
                CSR_ECFG:   csr_rd_value = {19'h0, lie_q};
                CSR_ESTAT:  csr_rd_value = {1'b0, esubcode_q, ecode_q, 3'b000, is_q};
                CSR_ERA:    csr_rd_value = era_q;
                CSR_BADV:   csr_rd_value = badv_q;
                CSR_EENTRY: csr_rd_value = {eentry_q, 6'h0};
                CSR_SAVE0:  csr_rd_value = save_q[0];
                CSR_SAVE1:  csr_rd_value = save_q[1];
                CSR_SAVE2:  csr_rd_value = save_q[2];
                CSR_SAVE3:  csr_rd_value = save_q[3];
                CSR_TID:    csr_rd_value = tid_q;
                CSR_TCFG:   csr_rd_value = tcfg_q;
                CSR_TVAL:   csr_rd_value = tval_q;
                default:    csr_rd_value = '0;
            endcase
        end
    end

    assign ex_entry   = {eentry_q, 6'h0};
    assign ertn_entry = era_q;
    assign has_int    = crmd_q[2] & (|(is_q & lie_q));

endmodule
